divisor_clk_param: RTL and testbench
====================================

DIVISOR_CLK_PARAM -- requirements
Module: divisor_clk_param

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent divider channels (1..16).
REQ-002 SHALL have parameter WIDTH, default 26, width of each channel's divide value and counter.
REQ-003 SHALL have parameter DIV_INIT, default 49999999, divide value loaded into every channel at reset (1 Hz from 100 MHz).
REQ-004 SHALL have port Clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port en, input, N_CH, per-channel run enable.
REQ-007 SHALL have port wr_en, input, 1, divide-value write strobe.
REQ-008 SHALL have port wr_ch, input, 4, target channel of write.
REQ-009 SHALL have port wr_div, input, WIDTH, divide value to write.
REQ-010 SHALL have port wr_ack, output, 1, one-cycle write-accepted pulse.
REQ-011 SHALL have port wr_err, output, 1, one-cycle write-rejected pulse.
REQ-012 SHALL have port DivClk, output, N_CH, divided clocks, 50% duty.
REQ-013 SHALL have port tick, output, N_CH, one-cycle strobe on every DivClk toggle.
REQ-014 SHALL have port pend, output, N_CH, shadow divide value awaiting commit.

Function
REQ-015 SHALL hold, per channel, active value div_act, shadow value div_sh, counter cnt (all WIDTH bits) and pend flag.
REQ-016 SHALL, with en[i]=1, increment cnt[i] each cycle; when cnt[i]==div_act[i], cnt[i]<=0, DivClk[i] toggles, tick[i]=1 that same registered cycle.
REQ-017 SHALL therefore produce half-period div_act+1 Clk cycles and full period 2*(div_act+1); div_act=0 gives Clk/2.
REQ-018 SHALL, on a terminal-count cycle with pend[i]=1, load div_act[i]<=div_sh[i] and clear pend[i]; new value governs the next half-period only (glitch-free change).
REQ-019 SHALL, with en[i]=0, hold cnt[i]=0, DivClk[i]=0, tick[i]=0, and commit any pending div_sh[i] to div_act[i] on the next edge, clearing pend[i].
REQ-020 SHALL, on en[i] rising, start counting from 0 with DivClk[i]=0; first toggle after div_act+1 enabled cycles.
REQ-021 SHALL, on wr_en=1 with wr_ch<N_CH, write div_sh[wr_ch]<=wr_div, set pend[wr_ch], pulse wr_ack the following cycle.
REQ-022 SHALL, on wr_en=1 with wr_ch>=N_CH, change no state and pulse wr_err the following cycle; wr_ack stays 0.
REQ-023 SHALL, on repeated writes to a pending channel, keep only the last value (last write wins).
REQ-024 SHALL, when a write and a terminal count hit the same channel in the same cycle, commit the old div_sh, then capture the new wr_div with pend remaining 1.
REQ-025 SHALL keep channels fully independent; a write or enable change on one channel never disturbs another's phase.
REQ-026 SHALL never let cnt exceed div_act; no counter wrap other than terminal-count reset.

Reset
REQ-027 SHALL, while reset=0, force cnt=0, div_act=div_sh=DIV_INIT, pend=0, DivClk=0, tick=0, wr_ack=0, wr_err=0 asynchronously.
REQ-028 SHALL, on reset asserted mid-period or mid-write, discard the write and pending values; first toggle after release occurs DIV_INIT+1 enabled cycles later.

Verification
REQ-029 SHALL verify: DIV_INIT=4, en=1111 after reset -> each DivClk toggles every 5 cycles (period 10), tick pulses coincide with toggles.
REQ-030 SHALL verify: ch1 running div=4, write wr_ch=1 wr_div=1 mid-half-period -> wr_ack next cycle, pend[1]=1 until terminal count, then half-period 2; other channels unchanged.
REQ-031 SHALL verify: wr_ch=7 with N_CH=4 -> wr_err one cycle, wr_ack=0, no pend bit set.
REQ-032 SHALL verify: ch0 write wr_div=0 with en[0]=0 -> pend clears next cycle; en[0]=1 -> DivClk[0]=Clk/2, first toggle after 1 cycle.
REQ-033 SHALL verify: reset=0 asserted between edges during a write -> all outputs 0 immediately, div_act=DIV_INIT after release, write lost.
REQ-034 SHALL verify: write coinciding with terminal count on ch2 (old pend value 2, new 6) -> next half-period 3 cycles, then 7 cycles.

Source files
------------

// File: rtl/divisor_clk_param.sv
// Multi-channel programmable clock divider with per-channel shadow divide values.
// Shadow values take effect only at a terminal count (or while idle) so every half-period stays whole.
module divisor_clk_param #(
    parameter int          N_CH     = 4,
    parameter int          WIDTH    = 26,
    parameter int unsigned DIV_INIT = 49999999
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  en,
    input  logic             wr_en,
    input  logic [3:0]       wr_ch,
    input  logic [WIDTH-1:0] wr_div,
    output logic             wr_ack,
    output logic             wr_err,
    output logic [N_CH-1:0]  DivClk,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  pend
);

    localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(DIV_INIT);
    localparam logic [4:0]       N_CH_W   = 5'(N_CH);

    logic w_wr_ok;
    logic r_wr_ack;
    logic r_wr_err;

    assign w_wr_ok = wr_en && ({1'b0, wr_ch} < N_CH_W);

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_wr_ack <= 1'b0;
            r_wr_err <= 1'b0;
        end else begin
            r_wr_ack <= w_wr_ok;
            r_wr_err <= wr_en && !w_wr_ok;
        end
    end

    assign wr_ack = r_wr_ack;
    assign wr_err = r_wr_err;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [WIDTH-1:0] r_cnt;
        logic [WIDTH-1:0] r_div_act;
        logic [WIDTH-1:0] r_div_sh;
        logic             r_pend;
        logic             r_divclk;
        logic             r_tick;
        logic             w_hit;
        logic             w_tc;

        assign w_hit = w_wr_ok && (wr_ch == 4'(gi));
        assign w_tc  = en[gi] && (r_cnt == r_div_act);

        always_ff @(posedge Clk or negedge reset) begin
            if (!reset) begin
                r_cnt     <= '0;
                r_div_act <= DIV_RST;
                r_div_sh  <= DIV_RST;
                r_pend    <= 1'b0;
                r_divclk  <= 1'b0;
                r_tick    <= 1'b0;
            end else begin
                if (!en[gi]) begin
                    r_cnt    <= '0;
                    r_divclk <= 1'b0;
                    r_tick   <= 1'b0;
                end else if (w_tc) begin
                    r_cnt    <= '0;
                    r_divclk <= ~r_divclk;
                    r_tick   <= 1'b1;
                end else begin
                    r_cnt  <= r_cnt + WIDTH'(1);
                    r_tick <= 1'b0;
                end
                // Commit uses the pre-write shadow; a same-cycle write then re-arms pend.
                if (r_pend && (!en[gi] || w_tc)) begin
                    r_div_act <= r_div_sh;
                    r_pend    <= 1'b0;
                end
                if (w_hit) begin
                    r_div_sh <= wr_div;
                    r_pend   <= 1'b1;
                end
            end
        end

        assign DivClk[gi] = r_divclk;
        assign tick[gi]   = r_tick;
        assign pend[gi]   = r_pend;
    end

endmodule

// File: tb/tb_divisor_clk_param.sv
// Directed bench for divisor_clk_param with DIV_INIT=4, N_CH=4; expected values hand-derived.
module tb_divisor_clk_param;

    localparam int N_CH     = 4;
    localparam int WIDTH    = 8;
    localparam int DIV_INIT = 4;

    logic             Clk = 1'b0;
    logic             reset;
    logic [N_CH-1:0]  en;
    logic             wr_en;
    logic [3:0]       wr_ch;
    logic [WIDTH-1:0] wr_div;
    logic             wr_ack;
    logic             wr_err;
    logic [N_CH-1:0]  DivClk;
    logic [N_CH-1:0]  tick;
    logic [N_CH-1:0]  pend;

    int errors = 0;
    int checks = 0;
    int tcnt[N_CH];
    int n;

    always #5 Clk = ~Clk;

    divisor_clk_param #(
        .N_CH    (N_CH),
        .WIDTH   (WIDTH),
        .DIV_INIT(DIV_INIT)
    ) dut (
        .Clk   (Clk),
        .reset (reset),
        .en    (en),
        .wr_en (wr_en),
        .wr_ch (wr_ch),
        .wr_div(wr_div),
        .wr_ack(wr_ack),
        .wr_err(wr_err),
        .DivClk(DivClk),
        .tick  (tick),
        .pend  (pend)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Returns the number of negedges until tick[ch] is seen, or -1 after 64 cycles.
    task automatic next_tick(input int ch, output int k);
        k = -1;
        for (int c = 1; c <= 64; c++) begin
            @(negedge Clk);
            if (tick[ch]) begin
                k = c;
                break;
            end
        end
    endtask

    task automatic count_ticks(input int ncyc);
        for (int c = 0; c < N_CH; c++) tcnt[c] = 0;
        repeat (ncyc) begin
            @(negedge Clk);
            for (int c = 0; c < N_CH; c++) if (tick[c]) tcnt[c]++;
        end
    endtask

    initial begin
        reset  = 1'b1;
        en     = '0;
        wr_en  = 1'b0;
        wr_ch  = '0;
        wr_div = '0;
        #1 reset = 1'b0;
        #1;
        chk("rst_divclk", 32'(DivClk), 32'd0);
        chk("rst_tick",   32'(tick),   32'd0);
        chk("rst_pend",   32'(pend),   32'd0);
        chk("rst_ack",    32'(wr_ack), 32'd0);
        chk("rst_err",    32'(wr_err), 32'd0);

        // All channels from reset: toggle every 5 cycles
        repeat (2) @(negedge Clk);
        reset = 1'b1;
        en    = 4'b1111;
        for (int k = 1; k <= 5; k++) begin
            @(negedge Clk);
            if (k < 5) begin
                chk("pre_tick",   32'(tick),   32'd0);
                chk("pre_divclk", 32'(DivClk), 32'd0);
            end else begin
                chk("first_divclk", 32'(DivClk), 32'hF);
                chk("first_tick",   32'(tick),   32'hF);
            end
        end
        next_tick(0, n);
        chk("half_period_ch0", 32'(n), 32'd5);
        chk("second_divclk", 32'(DivClk), 32'h0);
        chk("second_tick",   32'(tick),   32'hF);

        // Mid-half-period write to ch1
        repeat (2) @(negedge Clk);
        wr_en = 1'b1; wr_ch = 4'd1; wr_div = 8'd1;
        @(negedge Clk);
        wr_en = 1'b0;
        chk("ch1_ack",  32'(wr_ack), 32'd1);
        chk("ch1_err",  32'(wr_err), 32'd0);
        chk("ch1_pend", 32'(pend),   32'h2);
        next_tick(1, n);
        chk("ch1_commit_wait", 32'(n), 32'd2);
        chk("ch1_pend_clr", 32'(pend), 32'h0);
        chk("ch1_tc_all",   32'(tick), 32'hF);
        count_ticks(10);
        chk("win_ch0", 32'(tcnt[0]), 32'd2);
        chk("win_ch1", 32'(tcnt[1]), 32'd5);
        chk("win_ch2", 32'(tcnt[2]), 32'd2);
        chk("win_ch3", 32'(tcnt[3]), 32'd2);

        en = 4'b0000;
        @(negedge Clk);
        chk("dis_divclk", 32'(DivClk), 32'd0);
        chk("dis_tick",   32'(tick),   32'd0);

        // Out-of-range channel
        wr_en = 1'b1; wr_ch = 4'd7; wr_div = 8'd9;
        @(negedge Clk);
        wr_en = 1'b0;
        chk("bad_err",  32'(wr_err), 32'd1);
        chk("bad_ack",  32'(wr_ack), 32'd0);
        chk("bad_pend", 32'(pend),   32'd0);
        @(negedge Clk);
        chk("bad_err_pulse", 32'(wr_err), 32'd0);

        // Highest valid channel, idle: pend visible one cycle
        wr_en = 1'b1; wr_ch = 4'd3; wr_div = 8'd4;
        @(negedge Clk);
        wr_en = 1'b0;
        chk("ch3_ack",  32'(wr_ack), 32'd1);
        chk("ch3_err",  32'(wr_err), 32'd0);
        chk("ch3_pend", 32'(pend),   32'h8);
        @(negedge Clk);
        chk("ch3_pend_clr", 32'(pend), 32'h0);

        // ch0 div 0 while idle, then Clk/2
        wr_en = 1'b1; wr_ch = 4'd0; wr_div = 8'd0;
        @(negedge Clk);
        wr_en = 1'b0;
        chk("ch0_ack",  32'(wr_ack), 32'd1);
        chk("ch0_pend", 32'(pend),   32'h1);
        @(negedge Clk);
        chk("ch0_pend_clr", 32'(pend), 32'h0);
        en = 4'b0001;
        @(negedge Clk);
        chk("div2_c1_clk",  32'(DivClk[0]), 32'd1);
        chk("div2_c1_tick", 32'(tick[0]),   32'd1);
        @(negedge Clk);
        chk("div2_c2_clk",  32'(DivClk[0]), 32'd0);
        chk("div2_c2_tick", 32'(tick[0]),   32'd1);
        @(negedge Clk);
        chk("div2_c3_clk",  32'(DivClk[0]), 32'd1);
        en = 4'b0000;
        @(negedge Clk);
        chk("div2_off", 32'(DivClk), 32'd0);

        // ch2: pending 2, new write 6 coincides with terminal count
        en = 4'b0100;
        @(negedge Clk);
        wr_en = 1'b1; wr_ch = 4'd2; wr_div = 8'd2;
        @(negedge Clk);
        wr_en = 1'b0;
        chk("ch2_ack1",  32'(wr_ack), 32'd1);
        chk("ch2_pend1", 32'(pend),   32'h4);
        repeat (2) @(negedge Clk);
        wr_en = 1'b1; wr_ch = 4'd2; wr_div = 8'd6;
        @(negedge Clk);
        wr_en = 1'b0;
        chk("ch2_tc_tick", 32'(tick[2]),   32'd1);
        chk("ch2_tc_clk",  32'(DivClk[2]), 32'd1);
        chk("ch2_tc_pend", 32'(pend),      32'h4);
        chk("ch2_ack2",    32'(wr_ack),    32'd1);
        next_tick(2, n);
        chk("ch2_half3", 32'(n), 32'd3);
        chk("ch2_pend_clr", 32'(pend), 32'h0);
        next_tick(2, n);
        chk("ch2_half7", 32'(n), 32'd7);

        // Reset between edges during a write
        @(negedge Clk);
        wr_en = 1'b1; wr_ch = 4'd2; wr_div = 8'd1;
        #2 reset = 1'b0;
        #1;
        chk("arst_divclk", 32'(DivClk), 32'd0);
        chk("arst_tick",   32'(tick),   32'd0);
        chk("arst_pend",   32'(pend),   32'd0);
        chk("arst_ack",    32'(wr_ack), 32'd0);
        chk("arst_err",    32'(wr_err), 32'd0);
        @(negedge Clk);
        wr_en = 1'b0;
        reset = 1'b1;
        next_tick(2, n);
        chk("post_rst_first", 32'(n), 32'd5);
        chk("post_rst_pend",  32'(pend), 32'h0);
        next_tick(2, n);
        chk("post_rst_half", 32'(n), 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
